// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: builds Ethernet frames on the GMII transmit interface.
// Sends preamble, SFD, payload, optional zero padding, CRC-32 FCS and the
// inter-frame gap. Everything runs in the gmii_tx_clk domain.
//
// Build option: define GMII_TX_FRAMER_PAD_EN to zero-pad payloads shorter
// than MIN_DATA_LEN (padding covered by the FCS). Undefined: no PAD state.
//
// Ports:
//   gmii_tx_clk  in   transmit clock (only clock)
//   tx_rst       in   synchronous active-high reset
//   s_data[7:0]  in   payload byte
//   s_valid      in   payload byte valid
//   s_last       in   final payload byte of the frame (qualified by s_valid)
//   s_ready      out  byte consumed when s_valid && s_ready (PAYLOAD only)
//   gmii_tx_en   out  GMII transmit enable (registered)
//   gmii_txd     out  GMII transmit data (registered)
//   busy         out  high in every state except IDLE (registered)
//   tx_err       out  one-cycle pulse on a payload underrun
module gmii_tx_framer #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IFG_BYTES    = 12,
  parameter int unsigned MIN_DATA_LEN = 60
) (
  input  logic       gmii_tx_clk,
  input  logic       tx_rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       tx_err
);

  if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 15) begin : g_bad_preamble
    $error("PREAMBLE_LEN must be 1..15");
  end
  if (IFG_BYTES < 1 || IFG_BYTES > 255) begin : g_bad_ifg
    $error("IFG_BYTES must be 1..255");
  end
  if (MIN_DATA_LEN > 2047) begin : g_bad_min
    $error("MIN_DATA_LEN must not exceed 2047");
  end

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, PAYLOAD, FCS, IFG
`ifdef GMII_TX_FRAMER_PAD_EN
    , PAD
`endif
  } state_t;

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);
`ifdef GMII_TX_FRAMER_PAD_EN
  localparam logic [11:0] MIN_LEN = 12'(MIN_DATA_LEN);
`endif

  state_t      state;
  logic [7:0]  step_cnt;
  logic [10:0] byte_cnt;
  logic [31:0] crc;
  logic        fcs_bad;
  logic [31:0] fcs_word;
  logic [10:0] byte_cnt_inc;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign s_ready      = (state == PAYLOAD);
  // An underrun sends the un-inverted register, i.e. the complement of the good FCS.
  assign fcs_word     = fcs_bad ? crc : ~crc;
  assign byte_cnt_inc = (byte_cnt == '1) ? byte_cnt : byte_cnt + 11'd1;

  always_ff @(posedge gmii_tx_clk) begin
    if (tx_rst) begin
      state      <= IDLE;
      step_cnt   <= '0;
      byte_cnt   <= '0;
      crc        <= '1;
      fcs_bad    <= 1'b0;
      gmii_tx_en <= 1'b0;
      gmii_txd   <= '0;
      busy       <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      tx_err <= 1'b0;
      unique case (state)
        IDLE: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= '0;
          step_cnt   <= '0;
          if (s_valid) begin
            state <= PREAMBLE;
            busy  <= 1'b1;
          end
        end
        PREAMBLE: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= 8'h55;
          if (step_cnt == PRE_LAST) begin
            step_cnt <= '0;
            state    <= SFD;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        SFD: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= 8'hD5;
          crc        <= '1;
          byte_cnt   <= '0;
          fcs_bad    <= 1'b0;
          state      <= PAYLOAD;
        end
        PAYLOAD: begin
          gmii_tx_en <= 1'b1;
          if (s_valid) begin
            gmii_txd <= s_data;
            crc      <= crc32_byte(crc, s_data);
            byte_cnt <= byte_cnt_inc;
            if (s_last) begin
`ifdef GMII_TX_FRAMER_PAD_EN
              if (({1'b0, byte_cnt} + 12'd1) < MIN_LEN) state <= PAD;
              else                                      state <= FCS;
`else
              state <= FCS;
`endif
            end
          end else begin
            gmii_txd <= '0;
            tx_err   <= 1'b1;
            fcs_bad  <= 1'b1;
            state    <= FCS;
          end
        end
`ifdef GMII_TX_FRAMER_PAD_EN
        PAD: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= '0;
          crc        <= crc32_byte(crc, 8'h00);
          byte_cnt   <= byte_cnt_inc;
          if (({1'b0, byte_cnt} + 12'd1) >= MIN_LEN) state <= FCS;
        end
`endif
        FCS: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= fcs_word[{step_cnt[1:0], 3'b000} +: 8];
          if (step_cnt == 8'd3) begin
            step_cnt <= '0;
            state    <= IFG;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        IFG: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= '0;
          if (step_cnt == IFG_LAST) begin
            step_cnt <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed self-checking bench for gmii_tx_framer. dut drives the default
// configuration; dut2 uses PREAMBLE_LEN=3, IFG_BYTES=1.
module tb_gmii_tx_framer;

  localparam int MIN_LEN = 60;
`ifdef GMII_TX_FRAMER_PAD_EN
  localparam int PAD_TOTAL = 72;
`else
  localparam int PAD_TOTAL = 22;
`endif

  logic       clk = 1'b0;
  logic       tx_rst = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready, gmii_tx_en, busy, tx_err;
  logic [7:0] gmii_txd;

  logic       tx_rst2 = 1'b1;
  logic [7:0] s_data2 = '0;
  logic       s_valid2 = 1'b0;
  logic       s_last2 = 1'b0;
  logic       s_ready2, gmii_tx_en2, busy2, tx_err2;
  logic [7:0] gmii_txd2;

  int tests = 0;
  int fails = 0;

  gmii_tx_framer #(.PREAMBLE_LEN(7), .IFG_BYTES(12), .MIN_DATA_LEN(60)) dut (
    .gmii_tx_clk(clk), .tx_rst(tx_rst), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .gmii_tx_en(gmii_tx_en),
    .gmii_txd(gmii_txd), .busy(busy), .tx_err(tx_err)
  );

  gmii_tx_framer #(.PREAMBLE_LEN(3), .IFG_BYTES(1), .MIN_DATA_LEN(60)) dut2 (
    .gmii_tx_clk(clk), .tx_rst(tx_rst2), .s_data(s_data2), .s_valid(s_valid2),
    .s_last(s_last2), .s_ready(s_ready2), .gmii_tx_en(gmii_tx_en2),
    .gmii_txd(gmii_txd2), .busy(busy2), .tx_err(tx_err2)
  );

  always #4 clk = ~clk;

  // Per-cycle output log, sampled on the falling edge.
  logic       q_en[$];
  logic [7:0] q_txd[$];
  logic       q_en2[$];
  logic [7:0] q_txd2[$];
  int err_cnt = 0;
  int hs_cnt  = 0;

  always @(negedge clk) begin
    q_en.push_back(gmii_tx_en);
    q_txd.push_back(gmii_txd);
    q_en2.push_back(gmii_tx_en2);
    q_txd2.push_back(gmii_txd2);
    if (tx_err === 1'b1) err_cnt++;
    if (s_valid && s_ready) hs_cnt++;
  end

  logic [7:0] pay[0:63];
  logic [7:0] exp_q[$];

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Expected on-wire bytes (while tx_en is high) for a frame built from pay[].
  function automatic void build_exp(input int pre_len, input int len, input int ur_at);
    logic [31:0] c, fcs;
    int n;
    exp_q.delete();
    for (int i = 0; i < pre_len; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    n = (ur_at >= 0) ? ur_at : len;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pay[i]);
      c = crc_byte(c, pay[i]);
    end
    if (ur_at >= 0) begin
      exp_q.push_back(8'h00);
      fcs = c;
    end else begin
`ifdef GMII_TX_FRAMER_PAD_EN
      for (int i = n; i < MIN_LEN; i++) begin
        exp_q.push_back(8'h00);
        c = crc_byte(c, 8'h00);
      end
`endif
      fcs = ~c;
    end
    for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
  endfunction

  function automatic int first_en(input bit two, input int from);
    int sz = two ? q_en2.size() : q_en.size();
    for (int i = from; i < sz; i++) if (two ? q_en2[i] : q_en[i]) return i;
    return -1;
  endfunction

  function automatic int run_len(input bit two, input int at);
    int n = 0;
    int sz = two ? q_en2.size() : q_en.size();
    if (at < 0) return 0;
    for (int i = at; i < sz; i++) begin
      if (!(two ? q_en2[i] : q_en[i])) break;
      n++;
    end
    return n;
  endfunction

  function automatic int zeros_after(input int from);
    int n = 0;
    for (int i = from; i < q_en.size(); i++) begin
      if (q_en[i]) break;
      n++;
    end
    return n;
  endfunction

  // Number of logged bytes that differ from exp_q starting at index start.
  function automatic int frame_diff(input bit two, input int start);
    int d = 0;
    int sz = two ? q_txd2.size() : q_txd.size();
    if (start < 0) return exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (start + i >= sz) d++;
      else if ((two ? q_txd2[start + i] : q_txd[start + i]) !== exp_q[i]) d++;
    end
    return d;
  endfunction

  // Upstream model for dut: one byte per s_ready cycle; optional one-cycle
  // underrun or reset when byte index ur_at / rst_at is due.
  task automatic drive_frame(input int len, input int ur_at, input int rst_at);
    int idx = 0;
    int n = 0;
    logic rdy;
    while (idx < len && n < 1000) begin
      s_valid = 1'b1;
      s_data  = pay[idx];
      s_last  = (idx == len - 1);
      if (s_ready && idx == ur_at) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (s_ready && idx == rst_at) begin
        tx_rst  = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk); #1;
        tx_rst  = 1'b0;
        return;
      end
      rdy = s_ready;
      @(posedge clk); #1;
      if (rdy) idx++;
      n++;
    end
    tests++;
    if (idx != len) begin
      $display("FAIL drive_timeout: consumed=%0d required=%0d", idx, len);
      fails++;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      $display("FAIL %s_idle_timeout: busy=%b required=0", name, busy);
      fails++;
    end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests += 6;
    if (gmii_tx_en !== 1'b0) begin $display("FAIL rst_tx_en: got=%b exp=0", gmii_tx_en); fails++; end
    if (gmii_txd !== 8'h00)  begin $display("FAIL rst_txd: got=%h exp=00", gmii_txd); fails++; end
    if (s_ready !== 1'b0)    begin $display("FAIL rst_s_ready: got=%b exp=0", s_ready); fails++; end
    if (busy !== 1'b0)       begin $display("FAIL rst_busy: got=%b exp=0", busy); fails++; end
    if (tx_err !== 1'b0)     begin $display("FAIL rst_tx_err: got=%b exp=0", tx_err); fails++; end
    if ({gmii_tx_en2, busy2, tx_err2} !== 3'b000) begin
      $display("FAIL rst_dut2: got=%b exp=000", {gmii_tx_en2, busy2, tx_err2}); fails++;
    end
    tx_rst  = 1'b0;
    tx_rst2 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_crc_vector();
    int st, s, l;
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    st = q_en.size();
    drive_frame(9, -1, -1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_idle("crc");
    s = first_en(0, st);
    l = run_len(0, s);
    build_exp(7, 9, -1);
    tests += 3;
    if (l !== exp_q.size()) begin $display("FAIL crc_len: got=%0d exp=%0d", l, exp_q.size()); fails++; end
    if (frame_diff(0, s) !== 0) begin $display("FAIL crc_bytes: diffs=%0d exp=0", frame_diff(0, s)); fails++; end
    if (zeros_after(s + l) < 12) begin $display("FAIL crc_ifg: idle=%0d exp>=12", zeros_after(s + l)); fails++; end
`ifndef GMII_TX_FRAMER_PAD_EN
    tests += 2;
    if (l !== 21) begin $display("FAIL crc_len21: got=%0d exp=21", l); fails++; end
    if (s >= 0 && {q_txd[s+20], q_txd[s+19], q_txd[s+18], q_txd[s+17]} !== 32'hCBF43926) begin
      $display("FAIL crc_fcs: got=%h exp=cbf43926",
               {q_txd[s+20], q_txd[s+19], q_txd[s+18], q_txd[s+17]});
      fails++;
    end
`endif
  endtask

  task automatic test_padding();
    int st, s, l;
    for (int i = 0; i < 10; i++) pay[i] = 8'(i + 1);
    st = q_en.size();
    drive_frame(10, -1, -1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_idle("pad");
    s = first_en(0, st);
    l = run_len(0, s);
    build_exp(7, 10, -1);
    tests += 2;
    if (l !== PAD_TOTAL) begin $display("FAIL pad_len: got=%0d exp=%0d", l, PAD_TOTAL); fails++; end
    if (frame_diff(0, s) !== 0) begin $display("FAIL pad_bytes: diffs=%0d exp=0", frame_diff(0, s)); fails++; end
  endtask

  task automatic test_back_to_back();
    int st, s1, l1, s2, l2, h0;
    for (int i = 0; i < 64; i++) pay[i] = 8'(i * 3 + 1);
    st = q_en.size();
    h0 = hs_cnt;
    drive_frame(64, -1, -1);
    drive_frame(64, -1, -1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_idle("b2b");
    s1 = first_en(0, st);
    l1 = run_len(0, s1);
    s2 = first_en(0, s1 + l1);
    l2 = run_len(0, s2);
    build_exp(7, 64, -1);
    tests += 6;
    if (hs_cnt - h0 !== 128) begin $display("FAIL b2b_ready_count: got=%0d exp=128", hs_cnt - h0); fails++; end
    if (l1 !== 76) begin $display("FAIL b2b_len1: got=%0d exp=76", l1); fails++; end
    if (l2 !== 76) begin $display("FAIL b2b_len2: got=%0d exp=76", l2); fails++; end
    if (s2 - (s1 + l1) !== 13) begin $display("FAIL b2b_gap: got=%0d exp=13", s2 - (s1 + l1)); fails++; end
    if (frame_diff(0, s1) !== 0) begin $display("FAIL b2b_bytes1: diffs=%0d exp=0", frame_diff(0, s1)); fails++; end
    if (frame_diff(0, s2) !== 0) begin $display("FAIL b2b_bytes2: diffs=%0d exp=0", frame_diff(0, s2)); fails++; end
  endtask

  task automatic test_underrun();
    int st, s, l, e0;
    logic [31:0] c, rx_fcs;
    logic bad;
    for (int i = 0; i < 64; i++) pay[i] = 8'(8'hA0 ^ i);
    st = q_en.size();
    e0 = err_cnt;
    drive_frame(64, 20, -1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_idle("underrun");
    s = first_en(0, st);
    l = run_len(0, s);
    build_exp(7, 64, 20);
    // Receiver check: recompute FCS over everything after the SFD.
    c = 32'hFFFFFFFF;
    rx_fcs = '0;
    if (s >= 0 && l >= 12) begin
      for (int i = s + 8; i < s + l - 4; i++) c = crc_byte(c, q_txd[i]);
      rx_fcs = {q_txd[s+l-1], q_txd[s+l-2], q_txd[s+l-3], q_txd[s+l-4]};
    end
    bad = (~c !== rx_fcs);
    tests += 5;
    if (err_cnt - e0 !== 1) begin $display("FAIL ur_tx_err_pulses: got=%0d exp=1", err_cnt - e0); fails++; end
    if (l !== 33) begin $display("FAIL ur_len: got=%0d exp=33", l); fails++; end
    if (frame_diff(0, s) !== 0) begin $display("FAIL ur_bytes: diffs=%0d exp=0", frame_diff(0, s)); fails++; end
    if (bad !== 1'b1) begin $display("FAIL ur_rx_bad_fcs: got=%b exp=1", bad); fails++; end
    if (zeros_after(s + l) < 12) begin $display("FAIL ur_ifg: idle=%0d exp>=12", zeros_after(s + l)); fails++; end
  endtask

  task automatic test_reset_midframe();
    int st, s, l;
    for (int i = 0; i < 64; i++) pay[i] = 8'(i ^ 8'h5A);
    st = q_en.size();
    drive_frame(60, -1, 30);
    s_valid = 1'b0; s_last = 1'b0;
    tests += 3;
    if (gmii_tx_en !== 1'b0) begin $display("FAIL mrst_tx_en: got=%b exp=0", gmii_tx_en); fails++; end
    if (busy !== 1'b0)       begin $display("FAIL mrst_busy: got=%b exp=0", busy); fails++; end
    if (s_ready !== 1'b0)    begin $display("FAIL mrst_s_ready: got=%b exp=0", s_ready); fails++; end
    repeat (3) begin @(posedge clk); #1; end
    s = first_en(0, st);
    l = run_len(0, s);
    tests++;
    if (l !== 38) begin $display("FAIL mrst_partial_len: got=%0d exp=38", l); fails++; end
    for (int i = 0; i < 64; i++) pay[i] = 8'(i * 7);
    st = q_en.size();
    drive_frame(60, -1, -1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_idle("mrst");
    s = first_en(0, st);
    l = run_len(0, s);
    build_exp(7, 60, -1);
    tests += 2;
    if (l !== 72) begin $display("FAIL mrst_next_len: got=%0d exp=72", l); fails++; end
    if (frame_diff(0, s) !== 0) begin $display("FAIL mrst_next_bytes: diffs=%0d exp=0", frame_diff(0, s)); fails++; end
  endtask

  task automatic test_param_override();
    int st, s, l, s2, idx, n;
    logic rdy;
    pay[0] = 8'hAA;
    pay[1] = 8'hBB;
    st = q_en2.size();
    for (int f = 0; f < 2; f++) begin
      idx = 0;
      n = 0;
      while (idx < 2 && n < 200) begin
        s_valid2 = 1'b1;
        s_data2  = pay[idx];
        s_last2  = (idx == 1);
        rdy = s_ready2;
        @(posedge clk); #1;
        if (rdy) idx++;
        n++;
      end
      tests++;
      if (idx != 2) begin $display("FAIL ovr_drive_timeout: consumed=%0d required=2", idx); fails++; end
    end
    s_valid2 = 1'b0; s_last2 = 1'b0;
    n = 0;
    while (busy2 && n < 500) begin @(posedge clk); #1; n++; end
    tests++;
    if (busy2 !== 1'b0) begin $display("FAIL ovr_idle_timeout: busy=%b required=0", busy2); fails++; end
    repeat (3) begin @(posedge clk); #1; end
    s  = first_en(1, st);
    l  = run_len(1, s);
    s2 = first_en(1, s + l);
    build_exp(3, 2, -1);
    tests += 4;
    if (s >= 0 && {q_txd2[s], q_txd2[s+1], q_txd2[s+2], q_txd2[s+3]} !== 32'h555555D5) begin
      $display("FAIL ovr_preamble: got=%h exp=555555d5",
               {q_txd2[s], q_txd2[s+1], q_txd2[s+2], q_txd2[s+3]});
      fails++;
    end
    if (l !== exp_q.size()) begin $display("FAIL ovr_len: got=%0d exp=%0d", l, exp_q.size()); fails++; end
    if (frame_diff(1, s) !== 0) begin $display("FAIL ovr_bytes: diffs=%0d exp=0", frame_diff(1, s)); fails++; end
    if (s2 - (s + l) !== 2) begin $display("FAIL ovr_gap: got=%0d exp=2", s2 - (s + l)); fails++; end
  endtask

  initial begin
    test_reset();
    test_crc_vector();
    test_padding();
    test_back_to_back();
    test_underrun();
    test_reset_midframe();
    test_param_override();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
Builds complete Ethernet frames on the GMII transmit interface from a byte stream supplied by the packet builder (UDP/IP assembly of camera data). Emits preamble, SFD, payload, optional zero padding, CRC-32 FCS and the inter-frame gap. Its gmii_tx_en/gmii_txd outputs feed the RGMII DDR transmit stage directly. Runs entirely in the gmii_tx_clk domain (125 MHz).

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes sent before the SFD (valid range 1-15).
IFG_BYTES, 12, idle cycles (gmii_tx_en=0) enforced after the last FCS byte (valid range 1-255).
MIN_DATA_LEN, 60, minimum payload bytes before the FCS; applies only when padding is compiled in.

Ports:
gmii_tx_clk  input  1  GMII transmit clock, the only clock.
tx_rst  input  1  synchronous active-high reset.
s_data  input  8  payload byte.
s_valid  input  1  payload byte valid.
s_last  input  1  marks the final payload byte of a frame; qualified by s_valid.
s_ready  output  1  payload byte consumed this cycle when s_valid and s_ready are both high.
gmii_tx_en  output  1  GMII transmit enable, registered.
gmii_txd  output  8  GMII transmit data, registered.
busy  output  1  high in every state except IDLE.
tx_err  output  1  one-cycle pulse on a payload underrun.

Behaviour:
- Clocking/reset: single clock gmii_tx_clk; tx_rst is synchronous and active-high.
- On reset: state=IDLE; gmii_tx_en=0, gmii_txd=0x00, s_ready=0, busy=0, tx_err=0; all counters cleared; CRC=0xFFFFFFFF.
- Reset mid-frame: gmii_tx_en is low on the cycle after tx_rst is sampled high. No FCS and no IFG are sent. The partial payload is dropped.
- gmii_tx_en and gmii_txd are registered. The state in cycle k determines the outputs in cycle k+1.
- s_ready is combinational: high only in PAYLOAD. Upstream must then supply one byte per cycle until s_last.
- IDLE: when s_valid=1, go to PREAMBLE. No byte is consumed.
- PREAMBLE: drive 0x55 for PREAMBLE_LEN cycles, then go to SFD.
- SFD: drive 0xD5 for one cycle, initialise CRC to 0xFFFFFFFF, go to PAYLOAD.
- PAYLOAD: drive s_data and update the CRC and the byte count each cycle.
  - On s_last: go to PAD if padding is enabled and count+1 < MIN_DATA_LEN; otherwise go to FCS.
- PAD: drive 0x00 and include it in the CRC until the count reaches MIN_DATA_LEN, then go to FCS.
- FCS: drive 4 bytes of ~CRC, least-significant byte first, then go to IFG.
- IFG: gmii_tx_en=0 for exactly IFG_BYTES cycles, then go to IDLE.
  - s_valid held high through IFG starts the next preamble on the cycle after IDLE.
  - The minimum gap between frames is IFG_BYTES idle cycles plus one IDLE cycle.
- CRC-32 algorithm: reflected polynomial 0xEDB88320, processed LSB-first, one byte per cycle in combinational form.
- Underrun: s_valid=0 while in PAYLOAD.
  - Drive 0x00 that cycle; the byte is not counted.
  - Pulse tx_err for one cycle.
  - Skip PAD; go to FCS and send the bitwise inverse of the correct FCS (a deliberately bad frame).
  - Then go to IFG. Any remaining upstream bytes up to s_last must be flushed by upstream; the framer ignores them until IDLE.
- s_last together with s_valid=0 is ignored.
- Byte counter: 11 bits, saturates at 2047. Frames longer than 2047 bytes are sent, but the saturated count is not used for padding.
- busy is registered. It goes high the cycle after leaving IDLE and low when IDLE is re-entered.

Optional Feature:
Macro GMII_TX_FRAMER_PAD_EN.
- Defined: the PAD state exists. Payloads shorter than MIN_DATA_LEN are zero-padded, and the padding is covered by the FCS.
- Undefined: the PAD state and its comparator are removed. A short payload goes straight to FCS, and upstream is responsible for minimum length.

Test Plan:
- Macro off, payload ASCII "123456789" (9 bytes):
  - tx_en asserted for 7+1+9+4=21 cycles.
  - Output is 55×7, D5, 31..39, then FCS bytes 26 39 F4 CB (inverted in the final bytes only as required by CRC 0xCBF43926).
  - After the frame, 12 cycles with tx_en=0.
- Macro on, 10-byte payload 0x01..0x0A: bytes 0x01..0x0A are followed by 50 bytes of 0x00, then the FCS matching a reference model over the 60 bytes; 72 tx_en cycles in total.
- Two 64-byte frames with s_valid held high between them: the first byte of the second preamble appears exactly 13 cycles after the last FCS byte of the first frame. The s_ready count equals 128.
- Underrun, s_valid low for 1 cycle at payload byte 20 of 64:
  - tx_err pulses once.
  - A 0x00 byte is emitted, the FCS equals ~(correct CRC over 20 bytes) ^ 0xFFFFFFFF-inverse, and a receiver model flags a bad FCS.
  - The IFG follows.
- tx_rst asserted at payload byte 30: gmii_tx_en=0, busy=0, s_ready=0 on the next cycle. A following 60-byte frame is sent correctly with a valid FCS.
- PREAMBLE_LEN=3, IFG_BYTES=1 override: 55 55 55 D5 precede the payload, with a single idle cycle before the next IDLE.
